sincos_tone_sched: RTL and testbench

Scheduler that time-shares the single CORDIC sin/cos engine between two NCO tone channels. It generates the low-pass FIR test stimulus: a wanted in-band tone plus an out-of-band interferer.
- On each sample tick it issues two phases back-to-back to the CORDIC.
- It routes the two in-order results back to their channels and emits a combined sample for the FIR input.
- It owns both phase accumulators, the wrap arithmetic and the error/overrun monitoring.

---
 rtl/sincos_tone_sched.sv | 178 +++++++++++++++++
 tb/tb_sincos_tone_sched.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/sincos_tone_sched.sv
// Time-shares one CORDIC sin/cos engine between two NCO tone channels and
// emits a combined (sin0 + sin1) / 2 sample per tick.
module sincos_tone_sched #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned PI_Q    = 25736
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_tick,
  input  logic        phase_clr,
  input  logic [15:0] ftw0,
  input  logic [15:0] ftw1,
  output logic [15:0] phase,
  output logic        phase_tvalid,
  input  logic [15:0] sin_in,
  input  logic [15:0] cos_in,
  input  logic        sincos_tvalid,
  output logic [15:0] sin0,
  output logic [15:0] sin1,
  output logic [15:0] cos0,
  output logic [15:0] mix,
  output logic        mix_valid,
  output logic        busy,
  output logic        overrun,
  output logic        err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic signed [16:0] PiQ    = 17'(PI_Q);
  localparam logic signed [16:0] TwoPiQ = 17'(2 * PI_Q);
  localparam logic [15:0]        PiQU   = 16'(PI_Q);
  localparam logic [TW-1:0]      TimerLast = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StIssue0, StIssue1, StWait, StDone} state_e;

  state_e        state_q, state_d;
  logic [15:0]   acc0_q, acc0_d, acc1_q, acc1_d;
  logic [15:0]   sin0_q, sin0_d, sin1_q, sin1_d, cos0_q, cos0_d, mix_q, mix_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          got0_q, got0_d;
  logic          clr_pend_q, clr_pend_d;
  logic          overrun_q, overrun_d, err_q, err_d;
  logic [16:0]   mix_sum;

  // Clamp the increment to pi, add in 17 bits, fold back into [-pi, pi).
  function automatic logic [15:0] acc_step(input logic [15:0] acc, input logic [15:0] ftw);
    logic [15:0]        inc;
    logic signed [16:0] sum;
    inc = (ftw > PiQU) ? PiQU : ftw;
    sum = $signed({acc[15], acc}) + $signed({1'b0, inc});
    if (sum >= PiQ) begin
      sum = sum - TwoPiQ;
    end
    return sum[15:0];
  endfunction

  assign mix_sum = {sin0_q[15], sin0_q} + {sin_in[15], sin_in};

  always_comb begin
    state_d    = state_q;
    acc0_d     = acc0_q;
    acc1_d     = acc1_q;
    sin0_d     = sin0_q;
    sin1_d     = sin1_q;
    cos0_d     = cos0_q;
    mix_d      = mix_q;
    timer_d    = timer_q;
    got0_d     = got0_q;
    clr_pend_d = clr_pend_q | phase_clr;
    overrun_d  = overrun_q | (sample_tick && (state_q != StIdle));
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        // Clear lands before a same-cycle tick, so that frame issues phase 0.
        if (clr_pend_q || phase_clr) begin
          acc0_d     = '0;
          acc1_d     = '0;
          clr_pend_d = 1'b0;
        end
        if (sincos_tvalid) err_d = 1'b1;
        if (sample_tick) state_d = StIssue0;
      end
      StIssue0: begin
        acc0_d  = acc_step(acc0_q, ftw0);
        got0_d  = 1'b0;
        state_d = StIssue1;
      end
      StIssue1: begin
        acc1_d  = acc_step(acc1_q, ftw1);
        timer_d = '0;
        got0_d  = 1'b0;
        // A short-latency engine can return channel 0 already here.
        if (sincos_tvalid) begin
          sin0_d = sin_in;
          cos0_d = cos_in;
          got0_d = 1'b1;
        end
        state_d = StWait;
      end
      StWait: begin
        timer_d = timer_q + 1'b1;
        if (sincos_tvalid && got0_q) begin
          sin1_d  = sin_in;
          mix_d   = mix_sum[16:1];
          state_d = StDone;
        end else begin
          if (sincos_tvalid) begin
            sin0_d = sin_in;
            cos0_d = cos_in;
            got0_d = 1'b1;
          end
          if (timer_q == TimerLast) begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StDone: begin
        if (sincos_tvalid) err_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      acc0_q     <= '0;
      acc1_q     <= '0;
      sin0_q     <= '0;
      sin1_q     <= '0;
      cos0_q     <= '0;
      mix_q      <= '0;
      timer_q    <= '0;
      got0_q     <= 1'b0;
      clr_pend_q <= 1'b0;
      overrun_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc0_q     <= acc0_d;
      acc1_q     <= acc1_d;
      sin0_q     <= sin0_d;
      sin1_q     <= sin1_d;
      cos0_q     <= cos0_d;
      mix_q      <= mix_d;
      timer_q    <= timer_d;
      got0_q     <= got0_d;
      clr_pend_q <= clr_pend_d;
      overrun_q  <= overrun_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    phase        = '0;
    phase_tvalid = 1'b0;
    if (state_q == StIssue0) begin
      phase        = acc0_q;
      phase_tvalid = 1'b1;
    end else if (state_q == StIssue1) begin
      phase        = acc1_q;
      phase_tvalid = 1'b1;
    end
  end

  assign sin0      = sin0_q;
  assign sin1      = sin1_q;
  assign cos0      = cos0_q;
  assign mix       = mix_q;
  assign mix_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign overrun   = overrun_q;
  assign err       = err_q;

endmodule

// File: tb/tb_sincos_tone_sched.sv
// Directed bench for sincos_tone_sched: a 4-cycle CORDIC model feeds results back, and a
// scoreboard checks every issued phase and every mix sample.
module tb_sincos_tone_sched;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_tick = 1'b0;
  logic        phase_clr = 1'b0;
  logic [15:0] ftw0 = '0, ftw1 = '0;
  logic [15:0] phase, sin_in, cos_in;
  logic        phase_tvalid, sincos_tvalid;
  logic [15:0] sin0, sin1, cos0, mix;
  logic        mix_valid, busy, overrun, err;

  sincos_tone_sched #(.TIMEOUT(64), .PI_Q(25736)) dut (
    .clk(clk), .rst_n(rst_n), .sample_tick(sample_tick), .phase_clr(phase_clr),
    .ftw0(ftw0), .ftw1(ftw1), .phase(phase), .phase_tvalid(phase_tvalid),
    .sin_in(sin_in), .cos_in(cos_in), .sincos_tvalid(sincos_tvalid),
    .sin0(sin0), .sin1(sin1), .cos0(cos0), .mix(mix), .mix_valid(mix_valid),
    .busy(busy), .overrun(overrun), .err(err)
  );

  always #5 clk = ~clk;

  // CORDIC model: echo mode returns sin = phase, cos = ~phase; otherwise fixed values.
  logic        echo = 1'b1, drop_second = 1'b0;
  logic [15:0] fs0 = '0, fs1 = '0, fc = '0;
  logic [L-1:0] vpipe;
  logic [15:0]  spipe [L];
  logic [15:0]  cpipe [L];
  logic         ch;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
      ch    <= 1'b0;
      for (int i = 0; i < L; i++) begin
        spipe[i] <= '0;
        cpipe[i] <= '0;
      end
    end else begin
      vpipe    <= {vpipe[L-2:0], phase_tvalid && !(drop_second && ch)};
      spipe[0] <= echo ? phase : (ch ? fs1 : fs0);
      cpipe[0] <= echo ? ~phase : fc;
      for (int i = 1; i < L; i++) begin
        spipe[i] <= spipe[i-1];
        cpipe[i] <= cpipe[i-1];
      end
      if (phase_tvalid) ch <= ~ch;
    end
  end

  assign sincos_tvalid = vpipe[L-1];
  assign sin_in        = spipe[L-1];
  assign cos_in        = cpipe[L-1];

  typedef struct packed {
    logic [15:0] s0, s1, c0, m;
  } exp_t;

  exp_t        mix_q [$];
  logic [15:0] ph_q  [$];
  int tests = 0, fails = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: sample on the falling edge, pop and compare whenever the DUT presents output.
  always @(negedge clk) begin
    if (rst_n) begin
      if (phase_tvalid) begin
        if (ph_q.size() == 0) chk("phase_unexpected", phase, 16'hxxxx);
        else chk("phase", phase, ph_q.pop_front());
      end
      if (mix_valid) begin
        if (mix_q.size() == 0) begin
          chk("mix_unexpected", mix, 16'hxxxx);
        end else begin
          exp_t e;
          e = mix_q.pop_front();
          chk("sin0", sin0, e.s0);
          chk("sin1", sin1, e.s1);
          chk("cos0", cos0, e.c0);
          chk("mix", mix, e.m);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
  endtask

  task automatic clr();
    @(posedge clk); #1 phase_clr = 1'b1;
    @(posedge clk); #1 phase_clr = 1'b0;
  endtask

  task automatic exp_phases(input logic [15:0] p0, input logic [15:0] p1);
    ph_q.push_back(p0);
    ph_q.push_back(p1);
  endtask

  task automatic frame(input logic [15:0] p0, p1, s0, s1, c0, m);
    exp_phases(p0, p1);
    mix_q.push_back('{s0: s0, s1: s1, c0: c0, m: m});
    tick();
    repeat (39) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_phase"}, phase, 16'h0);
    chk({tag, "_phase_tvalid"}, {15'h0, phase_tvalid}, 16'h0);
    chk({tag, "_sin0"}, sin0, 16'h0);
    chk({tag, "_sin1"}, sin1, 16'h0);
    chk({tag, "_cos0"}, cos0, 16'h0);
    chk({tag, "_mix"}, mix, 16'h0);
    chk({tag, "_mix_valid"}, {15'h0, mix_valid}, 16'h0);
    chk({tag, "_busy"}, {15'h0, busy}, 16'h0);
    chk({tag, "_overrun"}, {15'h0, overrun}, 16'h0);
    chk({tag, "_err"}, {15'h0, err}, 16'h0);
  endtask

  int t1_ph  [10] = '{0, 6434, 12868, 19302, -25736, -19302, -12868, -6434, 0, 6434};
  int t1_mix [10] = '{0, 3217, 6434, 9651, -12868, -9651, -6434, -3217, 0, 3217};

  initial begin
    #1 chk_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single tone, ch1 idle: walk through the wrap at +pi.
    ftw0 = 16'd6434; ftw1 = 16'd0;
    for (int i = 0; i < 10; i++) begin
      frame(16'(t1_ph[i]), 16'h0, 16'(t1_ph[i]), 16'h0, ~16'(t1_ph[i]), 16'(t1_mix[i]));
    end
    chk("t1_err", {15'h0, err}, 16'h0);
    chk("t1_overrun", {15'h0, overrun}, 16'h0);

    // Increment above pi is clamped, then wraps straight to -pi.
    clr();
    ftw0 = 16'd30000;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) frame(16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0);
      else frame(16'(-25736), 16'h0, 16'(-25736), 16'h0, 16'd25735, 16'(-12868));
    end

    // Routing and mix arithmetic with fixed engine outputs.
    clr();
    ftw0 = 16'd0; ftw1 = 16'd0; echo = 1'b0;
    fs0 = 16'h2000; fs1 = 16'hE000; fc = 16'h1234;
    frame(16'h0, 16'h0, 16'h2000, 16'hE000, 16'h1234, 16'h0000);
    fs0 = 16'h7FFF; fs1 = 16'h7FFF; fc = 16'h0000;
    frame(16'h0, 16'h0, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF);

    // Tick three cycles into a frame is dropped and flags overrun.
    clr();
    echo = 1'b1; ftw0 = 16'd100; ftw1 = 16'd200;
    exp_phases(16'h0, 16'h0);
    mix_q.push_back('{s0: 16'h0, s1: 16'h0, c0: 16'hFFFF, m: 16'h0});
    tick();
    @(posedge clk); @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (40) @(posedge clk);
    #1 chk("t4_overrun", {15'h0, overrun}, 16'h1);
    frame(16'd100, 16'd200, 16'd100, 16'd200, ~16'd100, 16'd150);

    // Second result never comes back: frame abandoned after the timeout.
    drop_second = 1'b1;
    exp_phases(16'd200, 16'd400);
    tick();
    repeat (40) @(posedge clk);
    #1 chk("t5_busy_mid", {15'h0, busy}, 16'h1);
    chk("t5_err_mid", {15'h0, err}, 16'h0);
    repeat (50) @(posedge clk);
    #1 chk("t5_busy_after", {15'h0, busy}, 16'h0);
    chk("t5_err_after", {15'h0, err}, 16'h1);
    drop_second = 1'b0;
    frame(16'd300, 16'd600, 16'd300, 16'd600, ~16'd300, 16'd450);

    // Clear requested mid-frame takes effect only once back in IDLE.
    exp_phases(16'd400, 16'd800);
    mix_q.push_back('{s0: 16'd400, s1: 16'd800, c0: ~16'd400, m: 16'd600});
    tick();
    repeat (3) @(posedge clk);
    #1 phase_clr = 1'b1;
    @(posedge clk); #1 phase_clr = 1'b0;
    repeat (40) @(posedge clk);
    #1 frame(16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0);

    // Asynchronous reset in the middle of WAIT.
    exp_phases(16'd100, 16'd200);
    tick();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 chk("post_rst_err", {15'h0, err}, 16'h0);
    chk("post_rst_overrun", {15'h0, overrun}, 16'h0);
    frame(16'h0, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0);

    chk("ph_q_left", 16'(ph_q.size()), 16'h0);
    chk("mix_q_left", 16'(mix_q.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
